// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, oversampled majority-vote bit recovery,
// configurable frame format and a show-ahead receive FIFO with error tags.
module uart_rx #(
  parameter int    CLK_   = 50000000,
  parameter int    BAUD_  = 115200,
  parameter int    OVS_   = 16,
  parameter int    DATA_  = 8,
  parameter int    STOP_  = 1,
  parameter string PARITY = "none",
  parameter int    BUFF_  = 64
) (
  input  logic                    clk,
  input  logic                    rst_,
  input  logic                    rx,
  output logic [DATA_-1:0]        rd_data,
  output logic                    rd_perr,
  output logic                    rd_ferr,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [$clog2(BUFF_):0]  level,
  output logic                    overrun,
  output logic                    brk
);

  localparam int   DIV_    = (CLK_ + (BAUD_ * OVS_) / 2) / (BAUD_ * OVS_);
  localparam int   CW      = (DIV_ > 1) ? $clog2(DIV_) : 1;
  localparam int   OW      = $clog2(OVS_);
  localparam int   AW      = $clog2(BUFF_);
  localparam int   LW      = AW + 1;
  localparam int   WW      = DATA_ + 2;
  localparam int   MID     = OVS_ / 2;
  localparam logic HAS_PAR = (PARITY != "none");

  if (DIV_ < 2) begin : g_div_check
    $error("uart_rx: clock divider below 2, baud/oversampling too high for CLK_");
  end

  function automatic logic majority(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic exp_parity(input logic [DATA_-1:0] d);
    if (PARITY == "even")      return ^d;
    else if (PARITY == "odd")  return ~^d;
    else if (PARITY == "mark") return 1'b1;
    else                       return 1'b0;
  endfunction

  typedef enum logic [2:0] {
    S_WAITIDLE, S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [CW-1:0]    tick_cnt_q, tick_cnt_d;
  logic [OW-1:0]    ovs_q, ovs_d;
  logic [3:0]       bit_q, bit_d;
  logic             s0_q, s0_d, s1_q, s1_d;
  logic [DATA_-1:0] data_q, data_d;
  logic             perr_q, perr_d, ferr_q, ferr_d;
  logic [WW-1:0]    word_q, word_d;
  logic             push_q, push_d, brk_q, brk_d;
  logic             tick, at_vote, at_end, vote, ferr_fin;

  logic [WW-1:0]    mem_q [BUFF_];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             overrun_q, overrun_d;
  logic             full, pop, wr_en;
  logic [WW-1:0]    head;

  assign tick     = (tick_cnt_q == CW'(DIV_ - 1));
  assign at_vote  = (ovs_q == OW'(MID + 1));
  assign at_end   = (ovs_q == OW'(OVS_ - 1));
  assign vote     = majority(s0_q, s1_q, sync2_q);
  assign ferr_fin = ferr_q | ~vote;

  // Receive path: synchronizer, tick generation and frame FSM
  always_comb begin
    state_d    = state_q;
    sync1_d    = rx;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    ovs_d      = ovs_q;
    bit_d      = bit_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    data_d     = data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    word_d     = word_q;
    push_d     = 1'b0;
    brk_d      = 1'b0;
    case (state_q)
      // Qualified by a tick so the synchronizer has flushed its reset value.
      S_WAITIDLE: if (tick && sync2_q && prev_q) state_d = S_IDLE;
      S_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d    = S_START;
          tick_cnt_d = '0;
          ovs_d      = '0;
          bit_d      = '0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
        end
      end
      default: begin
        if (tick) begin
          ovs_d = at_end ? '0 : ovs_q + 1'b1;
          if (ovs_q == OW'(MID - 1)) s0_d = sync2_q;
          if (ovs_q == OW'(MID))     s1_d = sync2_q;
          case (state_q)
            S_START: begin
              if (at_vote && vote) state_d = S_IDLE;
              else if (at_end) begin
                state_d = S_DATA;
                bit_d   = '0;
              end
            end
            S_DATA: begin
              if (at_vote) data_d = {vote, data_q[DATA_-1:1]};
              if (at_end) begin
                if (bit_q == 4'(DATA_ - 1)) begin
                  bit_d   = '0;
                  state_d = HAS_PAR ? S_PAR : S_STOP;
                end else begin
                  bit_d = bit_q + 1'b1;
                end
              end
            end
            S_PAR: begin
              if (at_vote) perr_d = vote ^ exp_parity(data_q);
              if (at_end) begin
                bit_d   = '0;
                state_d = S_STOP;
              end
            end
            S_STOP: begin
              if (at_vote) begin
                ferr_d = ferr_fin;
                // Finish at mid-bit of the last stop bit to resync on the next edge.
                if (bit_q == 4'(STOP_ - 1)) begin
                  if (data_q == '0 && ferr_fin) begin
                    brk_d   = 1'b1;
                    state_d = S_WAITIDLE;
                  end else begin
                    push_d  = 1'b1;
                    word_d  = {ferr_fin, perr_q, data_q};
                    state_d = S_IDLE;
                  end
                end
              end else if (at_end) begin
                bit_d = bit_q + 1'b1;
              end
            end
            default: state_d = S_WAITIDLE;
          endcase
        end
      end
    endcase
  end

  // FIFO control
  always_comb begin
    full      = (level_q == LW'(BUFF_));
    pop       = rd_valid && rd_ready;
    wr_en     = push_q && (!full || pop);
    overrun_d = push_q && full && !pop;
    wr_ptr_d  = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({wr_en, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q    <= S_WAITIDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      tick_cnt_q <= '0;
      ovs_q      <= '0;
      bit_q      <= '0;
      push_q     <= 1'b0;
      brk_q      <= 1'b0;
      overrun_q  <= 1'b0;
      level_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      tick_cnt_q <= tick_cnt_d;
      ovs_q      <= ovs_d;
      bit_q      <= bit_d;
      push_q     <= push_d;
      brk_q      <= brk_d;
      overrun_q  <= overrun_d;
      level_q    <= level_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Datapath registers carry no reset; they are qualified by control state.
  always_ff @(posedge clk) begin
    s0_q   <= s0_d;
    s1_q   <= s1_d;
    data_q <= data_d;
    perr_q <= perr_d;
    ferr_q <= ferr_d;
    word_q <= word_d;
    if (wr_en) mem_q[wr_ptr_q] <= word_q;
  end

  assign head     = mem_q[rd_ptr_q];
  assign rd_valid = (level_q != '0);
  assign rd_data  = rd_valid ? head[DATA_-1:0] : '0;
  assign rd_perr  = rd_valid & head[DATA_];
  assign rd_ferr  = rd_valid & head[DATA_+1];
  assign level    = level_q;
  assign overrun  = overrun_q;
  assign brk      = brk_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an 8N1 receiver checked every cycle against a FIFO-level
// model, plus a 7E1 receiver checked with literal expectations.
module tb_uart_rx;
  localparam int BUFF = 4;
  localparam int BIT  = 432;

  logic       clk = 1'b0, rst_ = 1'b1, rx = 1'b1, rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic       rd_perr, rd_ferr, rd_valid, overrun, brk;
  logic [2:0] level;

  logic       rx2 = 1'b1, rd_ready2 = 1'b0;
  logic [6:0] rd_data2;
  logic       rd_perr2, rd_ferr2, rd_valid2, overrun2, brk2;
  logic [2:0] level2;

  int n_chk = 0, n_fail = 0;
  int ovr_cnt = 0, brk_cnt = 0, exp_ovr = 0, exp_brk = 0;
  bit settled = 1'b0;
  logic [9:0] mq [$];

  always #5 clk = ~clk;

  uart_rx #(.CLK_(50000000), .BAUD_(115200), .OVS_(16), .DATA_(8), .STOP_(1),
            .PARITY("none"), .BUFF_(BUFF)) u_dut (
    .clk(clk), .rst_(rst_), .rx(rx), .rd_data(rd_data), .rd_perr(rd_perr),
    .rd_ferr(rd_ferr), .rd_valid(rd_valid), .rd_ready(rd_ready), .level(level),
    .overrun(overrun), .brk(brk));

  uart_rx #(.CLK_(50000000), .BAUD_(115200), .OVS_(16), .DATA_(7), .STOP_(1),
            .PARITY("even"), .BUFF_(BUFF)) u_par (
    .clk(clk), .rst_(rst_), .rx(rx2), .rd_data(rd_data2), .rd_perr(rd_perr2),
    .rd_ferr(rd_ferr2), .rd_valid(rd_valid2), .rd_ready(rd_ready2), .level(level2),
    .overrun(overrun2), .brk(brk2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: head word, occupancy and validity on every cycle.
  always @(negedge clk) begin
    logic [13:0] act, exp;
    if (settled && !rst_) begin
      exp = {mq.size() != 0, 3'(mq.size()), (mq.size() != 0) ? mq[0] : 10'h000};
      act = {rd_valid, level, rd_ferr, rd_perr, rd_data};
      n_chk++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL fifo_model: actual %h required %h at %0t", act, exp, $time);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_) begin
      if (overrun) ovr_cnt++;
      if (brk)     brk_cnt++;
    end
  end

  // 8N1 frame; the push lands 4162 cycles after the start bit is driven.
  task automatic main_frame(input logic [7:0] d, input logic stop_v, input logic rdy);
    logic [9:0] seq;
    logic [9:0] w;
    logic       popd;
    seq = {stop_v, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = seq[i];
      if (i == 9) begin
        wait_cyc(273);
        if (rdy) rd_ready = 1'b1;
        wait_cyc(1);
        popd = rdy && (mq.size() != 0);
        w    = {~stop_v, 1'b0, d};
        if (d == 8'h00 && !stop_v) exp_brk++;
        else if (popd) begin
          void'(mq.pop_front());
          mq.push_back(w);
        end else if (mq.size() == BUFF) exp_ovr++;
        else mq.push_back(w);
        rd_ready = 1'b0;
        wait_cyc(BIT - 274);
      end else begin
        wait_cyc(BIT);
      end
    end
    check("frame_overrun_count", ovr_cnt, exp_ovr);
    check("frame_brk_count", brk_cnt, exp_brk);
  endtask

  task automatic pop_main();
    rd_ready = 1'b1;
    wait_cyc(1);
    if (mq.size() != 0) void'(mq.pop_front());
    rd_ready = 1'b0;
  endtask

  task automatic par_frame(input logic [6:0] d, input logic pbit);
    logic [9:0] seq;
    seq = {1'b1, pbit, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx2 = seq[i];
      wait_cyc(BIT);
    end
    rx2 = 1'b1;
  endtask

  task automatic par_seq();
    par_frame(7'h03, 1'b1);
    wait_cyc(200);
    check("par_valid_1", rd_valid2, 1);
    check("par_data_1", rd_data2, 7'h03);
    check("par_perr_1", rd_perr2, 1);
    check("par_ferr_1", rd_ferr2, 0);
    rd_ready2 = 1'b1;
    wait_cyc(1);
    rd_ready2 = 1'b0;
    check("par_level_after_pop", level2, 0);
    par_frame(7'h03, 1'b0);
    wait_cyc(200);
    check("par_data_2", rd_data2, 7'h03);
    check("par_perr_2", rd_perr2, 0);
    check("par_level_2", level2, 1);
    check("par_no_pulses", {overrun2, brk2}, 0);
  endtask

  task automatic main_seq();
    // Plain 8N1 word, held then consumed
    main_frame(8'hA5, 1'b1, 1'b0);
    wait_cyc(50);
    check("t1_valid", rd_valid, 1);
    check("t1_data", rd_data, 8'hA5);
    check("t1_flags", {rd_ferr, rd_perr}, 0);
    check("t1_level", level, 1);
    pop_main();
    check("t1_level_after_pop", level, 0);
    check("t1_data_when_empty", rd_data, 0);
    wait_cyc(400);

    // Framing error, then break
    main_frame(8'h41, 1'b0, 1'b0);
    rx = 1'b1;
    wait_cyc(500);
    check("t3_ferr", rd_ferr, 1);
    check("t3_ferr_data", rd_data, 8'h41);
    pop_main();
    main_frame(8'h00, 1'b0, 1'b0);
    wait_cyc(BIT * 2);
    check("t3_brk_once", brk_cnt, 1);
    check("t3_brk_level", level, 0);
    rx = 1'b1;
    wait_cyc(500);
    main_frame(8'h7E, 1'b1, 1'b0);
    wait_cyc(100);
    check("t3_after_brk", rd_data, 8'h7E);
    pop_main();

    // Short glitch rejected, then a real frame
    rx = 1'b0;
    wait_cyc(5 * 27);
    rx = 1'b1;
    wait_cyc(900);
    check("t4_glitch_level", level, 0);
    main_frame(8'h5A, 1'b1, 1'b0);
    wait_cyc(100);
    check("t4_data", rd_data, 8'h5A);
    pop_main();

    // Overrun and full push+pop
    for (int i = 1; i <= 5; i++) begin
      main_frame(8'(i), 1'b1, 1'b0);
      wait_cyc(100);
    end
    check("t5_level_full", level, 4);
    check("t5_head", rd_data, 8'h01);
    check("t5_overrun_once", ovr_cnt, 1);
    main_frame(8'h06, 1'b1, 1'b1);
    wait_cyc(100);
    check("t5_level_pushpop", level, 4);
    check("t5_head_pushpop", rd_data, 8'h02);
    check("t5_no_new_overrun", ovr_cnt, 1);
    for (int i = 0; i < 3; i++) pop_main();
    check("t5_last_word", rd_data, 8'h06);

    // Reset during data bit 3 with rx held low
    rx = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < 3; i++) begin
      rx = 1'b1;
      wait_cyc(BIT);
    end
    rx = 1'b0;
    wait_cyc(200);
    settled  = 1'b0;
    rst_     = 1'b1;
    wait_cyc(1);
    mq.delete();
    rst_     = 1'b0;
    settled  = 1'b1;
    check("t6_reset_level", level, 0);
    check("t6_reset_valid", rd_valid, 0);
    wait_cyc(600);
    rx = 1'b1;
    wait_cyc(900);
    check("t6_no_push", level, 0);
    main_frame(8'h3C, 1'b1, 1'b0);
    wait_cyc(100);
    check("t6_data", rd_data, 8'h3C);
    pop_main();
  endtask

  initial begin
    rst_ = 1'b1;
    wait_cyc(3);
    check("reset_state", {rd_valid, level, rd_ferr, rd_perr, rd_data, overrun, brk}, 0);
    rst_    = 1'b0;
    settled = 1'b1;
    wait_cyc(100);
    fork
      main_seq();
      par_seq();
    join
    check("total_overrun", ovr_cnt, exp_ovr);
    check("total_brk", brk_cnt, exp_brk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
